// File: rtl/invader_formation_renderer.sv
// Alien formation owner: alive bitmap, marching FSM with vblank-committed position,
// kill handshake, and a 2-stage per-pixel sprite lookup feeding the colour mixer.
module invader_formation_renderer #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int CELL_SH  = 5,
    parameter int START_X  = 64,
    parameter int START_Y  = 48,
    parameter int STEP_X   = 4,
    parameter int DROP_Y   = 16,
    parameter int MOVE_DIV = 8,
    parameter int X_LIMIT  = 640,
    parameter int BOTTOM_Y = 416
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       display_on,
    input  logic       frame_tick,
    input  logic       kill_valid,
    input  logic [2:0] kill_col,
    input  logic [1:0] kill_row,
    output logic       kill_ready,
    output logic       kill_hit,
    output logic       pixel_on,
    output logic [5:0] alive_count,
    output logic       all_dead,
    output logic       landed
);
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    typedef enum logic [1:0] {WAIT, CHECK, MOVE, DROP} state_t;

    // 8x8 sprites addressed {anim, row%2, sy}; bit sx is the pixel
    localparam logic [7:0] SPRITE_ROM [32] = '{
        8'h99, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'h81,
        8'h3C, 8'h7E, 8'hFF, 8'h99, 8'hFF, 8'h5A, 8'h81, 8'h42,
        8'h81, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h5A, 8'h81, 8'h42,
        8'h3C, 8'h7E, 8'hFF, 8'h99, 8'hFF, 8'h24, 8'h5A, 8'hA5
    };

    state_t                      state, state_n;
    logic [ROWS-1:0][COLS-1:0]   alive;
    logic [9:0]                  off_x, off_y, off_x_r, off_y_r;
    logic                        anim, anim_r, dir_right, drop_done;
    logic [DIV_W-1:0]            div_cnt;
    logic [COLS-1:0]             col_any;
    logic [ROWS-1:0]             row_any;
    int                          lc, rc, bot;
    logic                        hit_edge, kill_acc, kill_live, move_due;

    // ---------------- render pipe ----------------
    logic [10:0] dx, dy;
    logic        in_form;
    logic        s1_on, s1_in, s1_lx4, s1_ly4;
    logic [2:0]  s1_col, s1_sx, s1_sy;
    logic [1:0]  s1_row;

    assign dx      = {1'b0, x} - {1'b0, off_x_r};
    assign dy      = {1'b0, y} - {1'b0, off_y_r};
    assign in_form = !dx[10] && !dy[10] &&
                     (dx[9:0] < 10'(COLS << CELL_SH)) && (dy[9:0] < 10'(ROWS << CELL_SH));

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            s1_on <= 1'b0; s1_in <= 1'b0; s1_lx4 <= 1'b0; s1_ly4 <= 1'b0;
            s1_col <= '0; s1_row <= '0; s1_sx <= '0; s1_sy <= '0;
            pixel_on <= 1'b0;
        end else begin
            s1_on    <= display_on;
            s1_in    <= in_form;
            s1_col   <= 3'(dx[9:0] >> CELL_SH);
            s1_row   <= 2'(dy[9:0] >> CELL_SH);
            s1_lx4   <= dx[CELL_SH-1];
            s1_ly4   <= dy[CELL_SH-1];
            s1_sx    <= dx[3:1];
            s1_sy    <= dy[3:1];
            pixel_on <= s1_on && s1_in && alive[s1_row][s1_col] && !s1_lx4 && !s1_ly4 &&
                        SPRITE_ROM[{anim_r, s1_row[0], s1_sy}][s1_sx];
        end
    end

    // Raster only sees the marching position at the last vblank pixel
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            off_x_r <= 10'(START_X);
            off_y_r <= 10'(START_Y);
            anim_r  <= 1'b0;
        end else if (!display_on && x == 10'd639 && y == 10'd479) begin
            off_x_r <= off_x;
            off_y_r <= off_y;
            anim_r  <= anim;
        end
    end

    // ---------------- kill handshake ----------------
    assign kill_ready = (state == WAIT);
    assign kill_acc   = kill_valid && kill_ready;
    assign kill_live  = (int'(kill_col) < COLS) && (int'(kill_row) < ROWS) &&
                        alive[kill_row][kill_col];

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            alive       <= '1;
            alive_count <= 6'(COLS * ROWS);
            kill_hit    <= 1'b0;
            all_dead    <= 1'b0;
        end else begin
            kill_hit <= kill_acc && kill_live;
            all_dead <= (alive_count == 6'd0);
            if (kill_acc && kill_live) begin
                alive[kill_row][kill_col] <= 1'b0;
                alive_count               <= alive_count - 6'd1;
            end
        end
    end

    // ---------------- formation extents ----------------
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                col_any[c] = col_any[c] | alive[r][c];
                row_any[r] = row_any[r] | alive[r][c];
            end
        lc = 0; rc = 0; bot = 0;
        for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lc = c;
        for (int c = 0; c < COLS; c++)      if (col_any[c]) rc = c;
        for (int r = 0; r < ROWS; r++)      if (row_any[r]) bot = r;
    end

    assign hit_edge = dir_right ? (int'(off_x) + ((rc + 1) << CELL_SH) + STEP_X > X_LIMIT)
                                : (int'(off_x) < STEP_X + (lc << CELL_SH));
    assign move_due = frame_tick && !all_dead && !landed;

    // ---------------- motion FSM ----------------
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) state <= WAIT;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            WAIT:    if (move_due && div_cnt == DIV_W'(MOVE_DIV - 1)) state_n = CHECK;
            CHECK:   state_n = hit_edge ? DROP : MOVE;
            MOVE:    state_n = WAIT;
            DROP:    state_n = WAIT;
            default: state_n = WAIT;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            off_x     <= 10'(START_X);
            off_y     <= 10'(START_Y);
            dir_right <= 1'b1;
            anim      <= 1'b0;
            div_cnt   <= '0;
            drop_done <= 1'b0;
            landed    <= 1'b0;
        end else begin
            drop_done <= (state == DROP);
            if (drop_done && int'(off_y) + ((bot + 1) << CELL_SH) >= BOTTOM_Y) landed <= 1'b1;
            case (state)
                WAIT: if (move_due)
                    div_cnt <= (div_cnt == DIV_W'(MOVE_DIV - 1)) ? '0 : div_cnt + 1'b1;
                MOVE: begin
                    off_x <= dir_right ? off_x + 10'(STEP_X) : off_x - 10'(STEP_X);
                    anim  <= ~anim;
                end
                DROP: begin
                    off_y     <= off_y + 10'(DROP_Y);
                    dir_right <= ~dir_right;
                    anim      <= ~anim;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_invader_formation_renderer.sv
// Scoreboarded bench: pixel expectations queued at drive time, checked 2 cycles later.
module tb_invader_formation_renderer;
    logic       pixel_clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic       display_on = 1'b0, frame_tick = 1'b0, kill_valid = 1'b0;
    logic [2:0] kill_col = '0;
    logic [1:0] kill_row = '0;
    logic       kill_ready, kill_hit, pixel_on, all_dead, landed;
    logic [5:0] alive_count;

    int checks = 0, errors = 0;

    // reference formation state
    int              m_offx, m_offy, m_offx_r, m_offy_r, m_count;
    logic            m_anim, m_anim_r, m_dir, m_landed;
    logic [3:0][7:0] m_alive;

    logic [7:0] spr [32] = '{
        8'h99, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'h81,
        8'h3C, 8'h7E, 8'hFF, 8'h99, 8'hFF, 8'h5A, 8'h81, 8'h42,
        8'h81, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h5A, 8'h81, 8'h42,
        8'h3C, 8'h7E, 8'hFF, 8'h99, 8'hFF, 8'h24, 8'h5A, 8'hA5
    };

    invader_formation_renderer dut (
        .pixel_clk(pixel_clk), .reset(reset), .x(x), .y(y), .display_on(display_on),
        .frame_tick(frame_tick), .kill_valid(kill_valid), .kill_col(kill_col),
        .kill_row(kill_row), .kill_ready(kill_ready), .kill_hit(kill_hit),
        .pixel_on(pixel_on), .alive_count(alive_count), .all_dead(all_dead), .landed(landed)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic exp_pix(input int px, input int py);
        int lx, ly, col, row;
        lx = px - m_offx_r;
        ly = py - m_offy_r;
        if (lx < 0 || ly < 0 || lx >= 256 || ly >= 128) return 1'b0;
        col = lx / 32;
        row = ly / 32;
        if (!m_alive[row][col] || (lx % 32) >= 16 || (ly % 32) >= 16) return 1'b0;
        return spr[(int'(m_anim_r) * 16) + ((row % 2) * 8) + ((ly % 32) / 2)][(lx % 32) / 2];
    endfunction

    task automatic model_reset();
        m_offx = 64; m_offy = 48; m_offx_r = 64; m_offy_r = 48;
        m_anim = 0; m_anim_r = 0; m_dir = 1; m_landed = 0; m_count = 32; m_alive = '1;
    endtask

    task automatic model_move();
        logic [7:0] ca;
        logic [3:0] ra;
        int lc, rc, bot;
        logic hit_e;
        if (m_count == 0 || m_landed) return;
        ca = '0; ra = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                if (m_alive[r][c]) begin ca[c] = 1'b1; ra[r] = 1'b1; end
        lc = 0; rc = 0; bot = 0;
        for (int c = 7; c >= 0; c--) if (ca[c]) lc = c;
        for (int c = 0; c < 8; c++)  if (ca[c]) rc = c;
        for (int r = 0; r < 4; r++)  if (ra[r]) bot = r;
        hit_e  = m_dir ? (m_offx + (rc + 1) * 32 + 4 > 640) : (m_offx < 4 + lc * 32);
        m_anim = ~m_anim;
        if (hit_e) begin
            m_offy += 16;
            m_dir = ~m_dir;
            if (m_offy + (bot + 1) * 32 >= 416) m_landed = 1'b1;
        end else m_offx += m_dir ? 4 : -4;
    endtask

    // 8 back-to-back ticks, then settle through CHECK, MOVE/DROP and the landing test
    task automatic do_move();
        @(negedge pixel_clk); frame_tick = 1'b1;
        repeat (8) @(negedge pixel_clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge pixel_clk);
        model_move();
    endtask

    task automatic commit();
        @(negedge pixel_clk); x = 10'd639; y = 10'd479; display_on = 1'b0;
        @(negedge pixel_clk); x = '0; y = '0;
        m_offx_r = m_offx; m_offy_r = m_offy; m_anim_r = m_anim;
    endtask

    task automatic send_kill(input int c, input int r, output logic exp_hit);
        @(negedge pixel_clk);
        kill_valid = 1'b1; kill_col = 3'(c); kill_row = 2'(r);
        exp_hit = m_alive[r][c];
        if (exp_hit) begin m_alive[r][c] = 1'b0; m_count--; end
        @(negedge pixel_clk);
        kill_valid = 1'b0;
    endtask

    task automatic test_render(input string tag, input int py, input int px0, input int n);
        logic eq[$];
        int   xq[$];
        logic e;
        int   xx;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge pixel_clk);
            if (eq.size() == 2) begin
                e = eq.pop_front(); xx = xq.pop_front();
                checks++;
                if (pixel_on !== e) begin
                    errors++;
                    $display("FAIL %s pixel_on x=%0d y=%0d got %b exp %b", tag, xx, py, pixel_on, e);
                end
            end
            if (i < n) begin
                x = 10'(px0 + i); y = 10'(py); display_on = 1'b1;
                eq.push_back(exp_pix(px0 + i, py)); xq.push_back(px0 + i);
            end else begin
                x = '0; y = '0; display_on = 1'b0;
                eq.push_back(1'b0); xq.push_back(-1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge pixel_clk);
        checks++;
        if ({kill_ready, kill_hit, pixel_on, all_dead, landed, alive_count} !== {5'b10000, 6'd32}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b hit=%b pix=%b dead=%b land=%b cnt=%0d exp 1 0 0 0 0 32",
                     kill_ready, kill_hit, pixel_on, all_dead, landed, alive_count);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_pixel_basic();
        test_render("basic_top", 48, 60, 24);
        test_render("basic_above", 47, 60, 8);
        test_render("basic_row1", 80, 60, 24);
        test_render("basic_sprite_r5", 58, 96, 20);
    endtask

    task automatic test_move_commit();
        do_move();
        test_render("pre_commit", 48, 60, 24);
        commit();
        test_render("post_commit", 48, 60, 24);
    endtask

    task automatic test_right_edge();
        int guard = 0;
        while (m_dir && guard < 200) begin do_move(); guard++; end
        commit();
        test_render("drop_top", m_offy_r, m_offx_r - 4, 24);
        test_render("drop_above", m_offy_r - 1, m_offx_r - 4, 24);
        test_render("drop_right", m_offy_r, 600, 40);
    endtask

    task automatic test_kill();
        logic eh, d;
        int   guard, flips, cnt0;
        for (int r = 0; r < 4; r++) begin
            send_kill(7, r, eh);
            checks++;
            if (kill_hit !== eh || alive_count !== 6'(m_count)) begin
                errors++;
                $display("FAIL kill_col7 r%0d got hit=%b cnt=%0d exp hit=%b cnt=%0d", r, kill_hit, alive_count, eh, m_count);
            end
        end
        send_kill(7, 0, eh);
        checks++;
        if (kill_hit !== 1'b0 || alive_count !== 6'd28) begin
            errors++;
            $display("FAIL kill_dead got hit=%b cnt=%0d exp hit=0 cnt=28", kill_hit, alive_count);
        end
        // request raised during CHECK stays pending until WAIT
        cnt0 = m_count;
        @(negedge pixel_clk); frame_tick = 1'b1;
        repeat (8) @(negedge pixel_clk);
        frame_tick = 1'b0; kill_valid = 1'b1; kill_col = 3'd0; kill_row = 2'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge pixel_clk);
            checks++;
            if (kill_hit !== 1'b0 || alive_count !== 6'(cnt0) || kill_ready !== 1'(i)) begin
                errors++;
                $display("FAIL kill_not_ready c%0d got hit=%b cnt=%0d rdy=%b exp hit=0 cnt=%0d rdy=%0d",
                         i, kill_hit, alive_count, kill_ready, cnt0, i);
            end
        end
        @(negedge pixel_clk); kill_valid = 1'b0;
        model_move();
        m_alive[0][0] = 1'b0; m_count--;
        checks++;
        if (kill_hit !== 1'b1 || alive_count !== 6'(m_count)) begin
            errors++;
            $display("FAIL kill_held got hit=%b cnt=%0d exp hit=1 cnt=%0d", kill_hit, alive_count, m_count);
        end
        guard = 0; flips = 0;
        while (flips < 2 && guard < 500) begin
            d = m_dir; do_move(); guard++;
            if (m_dir != d) flips++;
        end
        commit();
        test_render("edge_col6", m_offy_r, m_offx_r + 188, 639 - (m_offx_r + 188));
        test_render("edge_left", m_offy_r + 32, m_offx_r - 4, 24);
    endtask

    task automatic test_landing();
        int guard = 0;
        while (!m_landed && guard < 3000) begin
            do_move(); guard++;
            checks++;
            if (landed !== m_landed) begin
                errors++;
                $display("FAIL landed_track move%0d got %b exp %b", guard, landed, m_landed);
            end
        end
        do_move();
        commit();
        test_render("landed_frozen", m_offy_r, m_offx_r - 4, 24);
        checks++;
        if (landed !== 1'b1 || kill_ready !== 1'b1) begin
            errors++;
            $display("FAIL landed_sticky got land=%b rdy=%b exp 1 1", landed, kill_ready);
        end
    endtask

    task automatic test_all_dead();
        logic eh;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                if (m_alive[r][c]) begin
                    send_kill(c, r, eh);
                    checks++;
                    if (kill_hit !== 1'b1 || alive_count !== 6'(m_count) || all_dead !== 1'b0) begin
                        errors++;
                        $display("FAIL kill_all c%0d r%0d got hit=%b cnt=%0d dead=%b exp 1 %0d 0",
                                 c, r, kill_hit, alive_count, all_dead, m_count);
                    end
                end
        @(negedge pixel_clk);
        checks++;
        if (all_dead !== 1'b1 || kill_hit !== 1'b0) begin
            errors++;
            $display("FAIL all_dead_assert got dead=%b hit=%b exp 1 0", all_dead, kill_hit);
        end
        do_move();
        checks++;
        if (all_dead !== 1'b1 || kill_ready !== 1'b1 || alive_count !== 6'd0) begin
            errors++;
            $display("FAIL all_dead_frozen got dead=%b rdy=%b cnt=%0d exp 1 1 0", all_dead, kill_ready, alive_count);
        end
    endtask

    task automatic test_reset_mid_check();
        test_reset();
        @(negedge pixel_clk); frame_tick = 1'b1;
        repeat (8) @(negedge pixel_clk);
        frame_tick = 1'b0;
        checks++;
        if (kill_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_check kill_ready got %b exp 0", kill_ready);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({kill_ready, kill_hit, pixel_on, all_dead, landed, alive_count} !== {5'b10000, 6'd32}) begin
            errors++;
            $display("FAIL reset_mid_check got rdy=%b hit=%b pix=%b dead=%b land=%b cnt=%0d exp 1 0 0 0 0 32",
                     kill_ready, kill_hit, pixel_on, all_dead, landed, alive_count);
        end
        @(negedge pixel_clk); reset = 1'b0;
        model_reset();
        test_render("after_reset", 48, 60, 24);
    endtask

    initial begin
        test_reset();
        test_pixel_basic();
        test_move_commit();
        test_right_edge();
        test_kill();
        test_landing();
        test_all_dead();
        test_reset_mid_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
